// File: rtl/eei_loader_pkg.sv
// Shared types and constants for the EEI program loader: FSM states, fault codes,
// and the header field length.
package eei_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_CNT,
    HDR_BASE,
    LOAD_WORD,
    WRITE,
    RUN,
    DONE,
    ERR
  } state_e;

  localparam logic [1:0] FAULT_COUNT = 2'b01;
  localparam logic [1:0] FAULT_ALIGN = 2'b10;
  localparam logic [1:0] FAULT_RANGE = 2'b11;

  localparam int unsigned HDR_BYTES = 4;

  function automatic logic accepts_bytes(input state_e s);
    return (s == HDR_CNT) || (s == HDR_BASE) || (s == LOAD_WORD);
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Shifts accepted bytes into a 32-bit little-endian word; flags the byte that
// completes it so the consumer can take the whole word on that same edge.
module byte_word_assembler
  import eei_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  byte_i,
  input  logic        xfer_i,
  output logic [31:0] word_o,
  output logic        complete_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] asm_q, asm_d;

  always_comb begin
    idx_d = idx_q;
    asm_d = asm_q;
    if (xfer_i) begin
      idx_d = idx_q + 2'd1;
      asm_d = {byte_i, asm_q[31:8]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      idx_q <= idx_d;
      asm_q <= asm_d;
    end
  end

  // Word is presented combinationally so the fourth byte is usable without a bubble.
  assign word_o     = asm_d;
  assign complete_o = xfer_i && (idx_q == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/eei_program_loader.sv
// Streams a length/base-prefixed program image into core program memory, then
// starts the core at the base address and reports its exit status.
module eei_program_loader
  import eei_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        acces_to_prog_mem,
  output logic        prog_rw,
  output logic        prog_valid,
  output logic [31:0] prog_addr,
  output logic [31:0] prog_data,
  output logic [1:0]  prog_byte_half_word,
  input  logic        prog_ready,
  input  logic        prog_out_of_range,
  output logic        core_start,
  output logic [31:0] initial_PC,
  input  logic        core_ready,
  input  logic [1:0]  core_exit_status,
  output logic        done,
  output logic        error,
  output logic [1:0]  exit_status
);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] base_q, base_d;
  logic [31:0] k_q, k_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  exit_q, exit_d;
  logic        byte_ready_q, acc_q, core_start_q, done_q, error_q;

  logic        byte_xfer;
  logic [31:0] word;
  logic        word_complete;

  assign byte_xfer = byte_valid && byte_ready_q;

  byte_word_assembler u_asm (
    .clk_i      (clk),
    .rst_ni     (rst),
    .byte_i     (byte_in),
    .xfer_i     (byte_xfer),
    .word_o     (word),
    .complete_o (word_complete)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    k_d     = k_q;
    addr_d  = addr_q;
    data_d  = data_q;
    exit_d  = exit_q;
    unique case (state_q)
      IDLE: begin
        k_d = '0;
        if (go) state_d = HDR_CNT;
      end
      HDR_CNT: begin
        if (word_complete) begin
          cnt_d = word;
          if (word > 32'(MAX_WORDS)) begin
            state_d = ERR;
            exit_d  = FAULT_COUNT;
          end else begin
            state_d = HDR_BASE;
          end
        end
      end
      HDR_BASE: begin
        if (word_complete) begin
          base_d = word;
          addr_d = word;
          if (word[1:0] != 2'b00) begin
            state_d = ERR;
            exit_d  = FAULT_ALIGN;
          end else if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            state_d = LOAD_WORD;
          end
        end
      end
      LOAD_WORD: begin
        if (word_complete) begin
          data_d  = word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (prog_out_of_range) begin
          state_d = ERR;
          exit_d  = FAULT_RANGE;
        end else if (prog_ready) begin
          k_d    = k_q + 32'd1;
          addr_d = addr_q + 32'd4;
          state_d = (k_q + 32'd1 == cnt_q) ? RUN : LOAD_WORD;
        end
      end
      RUN: begin
        if (core_ready) begin
          exit_d  = core_exit_status;
          state_d = DONE;
        end
      end
      DONE, ERR: begin
        if (!go) begin
          exit_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      k_q          <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      exit_q       <= '0;
      byte_ready_q <= 1'b0;
      acc_q        <= 1'b0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      k_q          <= k_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      exit_q       <= exit_d;
      byte_ready_q <= accepts_bytes(state_d);
      acc_q        <= (state_d == WRITE);
      core_start_q <= (state_d == RUN);
      done_q       <= (state_d == DONE) || (state_d == ERR);
      error_q      <= (state_d == ERR);
    end
  end

  assign byte_ready          = byte_ready_q;
  assign acces_to_prog_mem   = acc_q;
  assign prog_valid          = acc_q;
  assign prog_rw             = acc_q;
  assign prog_addr           = acc_q ? addr_q : '0;
  assign prog_data           = acc_q ? data_q : '0;
  assign prog_byte_half_word = 2'b00;
  assign core_start          = core_start_q;
  assign initial_PC          = core_start_q ? base_q : '0;
  assign done                = done_q;
  assign error               = error_q;
  assign exit_status         = exit_q;

endmodule

// File: tb/tb_eei_program_loader.sv
// Directed bench for eei_program_loader: table of load sessions plus a reset-mid-word sequence.
module tb_eei_program_loader;

  localparam int unsigned TB_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        prog_ready = 1'b0;
  logic        prog_out_of_range = 1'b0;
  logic        core_ready = 1'b0;
  logic [1:0]  core_exit_status = '0;
  logic        byte_ready, acces_to_prog_mem, prog_rw, prog_valid, core_start, done, error;
  logic [31:0] prog_addr, prog_data, initial_PC;
  logic [1:0]  prog_byte_half_word, exit_status;

  eei_program_loader #(.MAX_WORDS(TB_MAX)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .go                  (go),
    .byte_in             (byte_in),
    .byte_valid          (byte_valid),
    .byte_ready          (byte_ready),
    .acces_to_prog_mem   (acces_to_prog_mem),
    .prog_rw             (prog_rw),
    .prog_valid          (prog_valid),
    .prog_addr           (prog_addr),
    .prog_data           (prog_data),
    .prog_byte_half_word (prog_byte_half_word),
    .prog_ready          (prog_ready),
    .prog_out_of_range   (prog_out_of_range),
    .core_start          (core_start),
    .initial_PC          (initial_PC),
    .core_ready          (core_ready),
    .core_exit_status    (core_exit_status),
    .done                (done),
    .error               (error),
    .exit_status         (exit_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      n;
    logic [31:0]      base;
    logic [3:0][31:0] w;
    logic [1:0]       core_st;
    int unsigned      rdelay;
    bit               gaps;
    bit               oor;
    bit               exp_err;
    logic [1:0]       exp_st;
  } vec_t;

  int          checks = 0;
  int          errors = 0;

  // Stimulus knobs, written only by the main process.
  int unsigned rdelay = 0;
  bit          oor_mode = 1'b0;
  bit          cur_gaps = 1'b0;
  logic [1:0]  core_st = '0;
  bit          ab = 1'b0;

  // Program-memory responder and write recorder.
  int unsigned wr_cnt = 0;
  int unsigned wr_wait = 0;
  logic [31:0] wr_a [8];
  logic [31:0] wr_d [8];
  logic [31:0] cur_a = '0, cur_d = '0;
  bit          wstab_bad = 1'b0;

  always @(negedge clk) begin
    if (prog_valid) begin
      if (wr_wait == 0) begin
        cur_a = prog_addr;
        cur_d = prog_data;
      end else if (prog_addr !== cur_a || prog_data !== cur_d) begin
        wstab_bad = 1'b1;
      end
      if (byte_ready || !prog_rw || !acces_to_prog_mem) wstab_bad = 1'b1;
      if (wr_wait == rdelay) begin
        prog_ready = 1'b1;
        prog_out_of_range = oor_mode;
        if (!oor_mode) begin
          if (wr_cnt < 8) begin
            wr_a[wr_cnt] = prog_addr;
            wr_d[wr_cnt] = prog_data;
          end
          wr_cnt++;
        end
      end
      wr_wait++;
    end else begin
      prog_ready = 1'b0;
      prog_out_of_range = 1'b0;
      wr_wait = 0;
    end
    if (!go) begin
      wr_cnt = 0;
      wstab_bad = 1'b0;
    end
  end

  // Core model: answers a few cycles after core_start, records the entry PC.
  int unsigned core_wait = 0;
  logic [31:0] pc_seen = '0;
  bit          pc_got = 1'b0;
  bit          pcstab_bad = 1'b0;

  always @(negedge clk) begin
    if (core_start) begin
      if (!pc_got) begin
        pc_seen = initial_PC;
        pc_got  = 1'b1;
      end else if (initial_PC !== pc_seen) begin
        pcstab_bad = 1'b1;
      end
      if (core_wait == 2) begin
        core_ready = 1'b1;
        core_exit_status = core_st;
      end
      core_wait++;
    end else begin
      core_ready = 1'b0;
      core_wait = 0;
    end
    if (!go) begin
      pc_got = 1'b0;
      pcstab_bad = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (ab) return;
    if (cur_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    for (int c = 0; ; c++) begin
      if (byte_ready) begin
        @(negedge clk);
        break;
      end
      if (done) begin
        ab = 1'b1;
        break;
      end
      if (c >= 100) begin
        ab = 1'b1;
        checks++;
        errors++;
        $display("FAIL byte_timeout: byte_ready stayed 0, required 1");
        break;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic run_session(input int id, input vec_t v);
    int unsigned nexp;
    ab = 1'b0;
    rdelay = v.rdelay;
    oor_mode = v.oor;
    cur_gaps = v.gaps;
    core_st = v.core_st;
    go = 1'b1;
    send_word(v.n);
    send_word(v.base);
    for (int i = 0; i < 4 && 32'(i) < v.n; i++) send_word(v.w[i]);
    for (int c = 0; c < 300 && !done; c++) @(negedge clk);
    check($sformatf("s%0d done", id), 32'(done), 32'd1);
    check($sformatf("s%0d error", id), 32'(error), 32'(v.exp_err));
    check($sformatf("s%0d exit_status", id), 32'(exit_status), 32'(v.exp_st));
    check($sformatf("s%0d core_start_off", id), 32'(core_start), 32'd0);
    nexp = v.exp_err ? 0 : v.n;
    check($sformatf("s%0d write_count", id), wr_cnt, nexp);
    for (int i = 0; i < 4 && i < int'(nexp); i++) begin
      check($sformatf("s%0d wr%0d addr", id, i), wr_a[i], v.base + 32'(4 * i));
      check($sformatf("s%0d wr%0d data", id, i), wr_d[i], v.w[i]);
    end
    check($sformatf("s%0d write_stable", id), 32'(wstab_bad), 32'd0);
    if (!v.exp_err) begin
      check($sformatf("s%0d pc_seen", id), 32'(pc_got), 32'd1);
      check($sformatf("s%0d initial_PC", id), pc_seen, v.base);
      check($sformatf("s%0d pc_stable", id), 32'(pcstab_bad), 32'd0);
    end
    repeat (3) @(negedge clk);
    check($sformatf("s%0d done_hold", id), 32'(done), 32'd1);
    check($sformatf("s%0d status_hold", id), 32'(exit_status), 32'(v.exp_st));
    go = 1'b0;
    repeat (2) @(negedge clk);
    check($sformatf("s%0d idle_done", id), 32'(done), 32'd0);
    check($sformatf("s%0d idle_error", id), 32'(error), 32'd0);
    check($sformatf("s%0d idle_status", id), 32'(exit_status), 32'd0);
    check($sformatf("s%0d idle_ready", id), 32'(byte_ready), 32'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] n, input logic [31:0] base,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [1:0] cst, input int unsigned rd,
                              input bit gaps, input bit oor, input bit exp_err,
                              input logic [1:0] exp_st);
    vec_t v;
    v.n = n; v.base = base;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.core_st = cst; v.rdelay = rd; v.gaps = gaps; v.oor = oor;
    v.exp_err = exp_err; v.exp_st = exp_st;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst byte_ready", 32'(byte_ready), 32'd0);
    check("rst access", 32'(acces_to_prog_mem), 32'd0);
    check("rst prog_valid", 32'(prog_valid), 32'd0);
    check("rst prog_rw", 32'(prog_rw), 32'd0);
    check("rst core_start", 32'(core_start), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst error", 32'(error), 32'd0);
    check("rst exit_status", 32'(exit_status), 32'd0);
    check("rst half_word", 32'(prog_byte_half_word), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    //             n      base          w0            w1            w2            w3        cst  rd gap oor err st
    vecs.push_back(mk(2, 32'h100,      32'h00000013, 32'h00100073, 32'h0,        32'h0,        2'b00, 0, 0, 0, 0, 2'b00));
    vecs.push_back(mk(5, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        2'b00, 0, 0, 0, 1, 2'b01));
    vecs.push_back(mk(1, 32'h102,      32'h1,        32'h0,        32'h0,        32'h0,        2'b00, 0, 0, 0, 1, 2'b10));
    vecs.push_back(mk(0, 32'h40,       32'h0,        32'h0,        32'h0,        32'h0,        2'b10, 0, 0, 0, 0, 2'b10));
    vecs.push_back(mk(2, 32'hFFFFFFFC, 32'hDEADBEEF, 32'h12345678, 32'h0,        32'h0,        2'b01, 5, 0, 0, 0, 2'b01));
    vecs.push_back(mk(2, 32'h200,      32'hAAAA5555, 32'h0,        32'h0,        32'h0,        2'b00, 0, 0, 1, 1, 2'b11));
    vecs.push_back(mk(2, 32'h100,      32'h00000013, 32'h00100073, 32'h0,        32'h0,        2'b11, 2, 1, 0, 0, 2'b11));
    vecs.push_back(mk(4, 32'h1000,     32'h01020304, 32'hA5A5A5A5, 32'h0000FFFF, 32'h80000001, 2'b00, 1, 1, 0, 0, 2'b00));

    foreach (vecs[i]) run_session(i, vecs[i]);

    // Reset in the middle of the first program word, then a clean reload.
    ab = 1'b0;
    cur_gaps = 1'b0;
    go = 1'b1;
    send_word(32'd2);
    send_word(32'h300);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b0;
    go = 1'b0;
    #1;
    check("midrst byte_ready", 32'(byte_ready), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst access", 32'(acces_to_prog_mem), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_session(100, mk(2, 32'h300, 32'h11223344, 32'h55667788, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eei_program_loader.md
EEI_PROGRAM_LOADER -- requirements
Module: eei_program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024, maximum program length in 32-bit words accepted from the header.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 go  input  1  level; sampled in IDLE to begin a load-and-run session.
REQ-005 byte_in  input  8  serial load stream data.
REQ-006 byte_valid  input  1  byte_in valid; a byte transfers on a cycle with byte_valid & byte_ready.
REQ-007 byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 acces_to_prog_mem  output  1  loader owns the core's program-memory port.
REQ-009 prog_rw / prog_valid  output  1 / 1  program-memory write strobe pair.
REQ-010 prog_addr / prog_data  output  32 / 32  program-memory word address and data.
REQ-011 prog_byte_half_word  output  2  constant 2'b00, word access.
REQ-012 prog_ready / prog_out_of_range  input  1 / 1  program-memory handshake from core.
REQ-013 core_start / initial_PC  output  1 / 32  core run request and entry PC.
REQ-014 core_ready / core_exit_status  input  1 / 2  core finished and its exit code.
REQ-015 done / error  output  1 / 1  session finished; loader fault.
REQ-016 exit_status  output  2  latched core exit code, or fault code when error=1.

Function
REQ-017 Stream format: 4-byte word count N, then 4-byte base address B, then N 4-byte words; all little-endian, first byte in bits [7:0].
REQ-018 FSM states: IDLE, HDR_CNT, HDR_BASE, LOAD_WORD, WRITE, RUN, DONE, ERR.
REQ-019 IDLE: all outputs deasserted; go=1 -> HDR_CNT.
REQ-020 byte_ready=1 only in HDR_CNT, HDR_BASE, and LOAD_WORD; bytes offered in other states are neither consumed nor buffered.
REQ-021 A 2-bit byte index wraps 3->0; the fourth accepted byte completes the word, and the state advances on the next edge.
REQ-022 HDR_CNT complete: N > MAX_WORDS -> ERR, code 2'b01; otherwise -> HDR_BASE.
REQ-023 HDR_BASE complete: B[1:0] != 0 -> ERR, code 2'b10; N == 0 -> RUN; otherwise -> LOAD_WORD.
REQ-024 LOAD_WORD complete -> WRITE.
REQ-025 WRITE: acces_to_prog_mem=1, prog_valid=1, prog_rw=1, prog_addr=B+4*k, prog_data=word k; all held stable until prog_ready or prog_out_of_range.
REQ-026 WRITE with prog_out_of_range=1 -> ERR, code 2'b11; this takes priority over prog_ready in the same cycle.
REQ-027 WRITE with prog_ready=1: increment k; if k reaches N -> RUN, else -> LOAD_WORD.
REQ-028 Address arithmetic is 32-bit modulo, so wrap past 0xFFFFFFFC is permitted.
REQ-029 acces_to_prog_mem=0 in every state except WRITE.
REQ-030 RUN: core_start=1 and initial_PC=B held stable; on core_ready=1, latch core_exit_status and go to DONE; core_start drops in DONE.
REQ-031 DONE: done=1 and exit_status is held; go=0 -> IDLE; go held high keeps DONE.
REQ-032 ERR: done=1, error=1, exit_status=fault code; go=0 -> IDLE.
REQ-033 Latency: one extra cycle per word after its fourth byte, plus the prog_ready wait.

Reset
REQ-034 rst=0 forces IDLE immediately, including mid-word or mid-run.
REQ-035 On reset, the following clear to 0: byte index, k, N, B, the assembly register, done, error, exit_status, core_start, prog_valid, prog_rw, and acces_to_prog_mem.
REQ-036 A partially assembled word is discarded on reset.

Structure
REQ-037 Package eei_loader_pkg holds: the state enum, the fault codes (01 count, 10 alignment, 11 range), and the header length constant 4.
REQ-038 One sub-module, byte_word_assembler, performs the 4-byte little-endian shift-in and asserts word_complete.

Verification
REQ-039 Load N=2, B=0x100, words 0x00000013, 0x00100073; core_ready=1 with status 00 -> two writes at 0x100 and 0x104, initial_PC=0x100, done=1, exit_status=00.
REQ-040 N=MAX_WORDS+1 -> ERR after the 4th byte, error=1, exit_status=01, no write issued.
REQ-041 B=0x102 -> ERR, exit_status=10; N=0 with B=0x40 -> RUN directly, initial_PC=0x40.
REQ-042 prog_ready delayed 5 cycles -> addr and data stable throughout, byte_ready=0; prog_out_of_range and prog_ready both 1 -> ERR, exit_status=11.
REQ-043 byte_valid toggled randomly -> the same memory image is written; rst=0 after 2 bytes of word 1 -> IDLE, and a fresh session loads correctly.
